// File: rtl/core_sequencer_pkg.sv
// Shared encodings for the core sequencer: FSM states, the SYSTEM opcode
// and the default PC-select width used by the fetch PC mux.
package core_sequencer_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_DE    = 2'b01,
        S_MW    = 2'b10,
        S_HALT  = 2'b11
    } seq_state_t;

    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam int         SEL_PC_WIDTH = 2;

    function automatic logic is_system(input logic [6:0] opcode);
        return opcode == OPC_SYSTEM;
    endfunction

endpackage

// File: rtl/core_sequencer_wait_timer.sv
// Memory/writeback wait timer: counts stalled S_MW cycles and flags expiry
// on the cycle the count sits at MEM_TIMEOUT-1 while still waiting.
module seq_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int             TW   = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0]  TERM = TW'(MEM_TIMEOUT - 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    // A zero MEM_TIMEOUT disables expiry; the counter simply free-runs.
    assign expired = (MEM_TIMEOUT != 0) && en && (cnt_q == TERM);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer for the fetch / decode-execute / memory-writeback
// datapath: stall and PC control, commit, halt detection and retire count.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int          SEL_PC_W       = SEL_PC_WIDTH,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          MEM_TIMEOUT    = 16,
    parameter int          CNT_W          = 32,
    parameter bit          HALT_ON_SYSTEM = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memory_done,
    input  logic [SEL_PC_W-1:0] pc_sel,
    input  logic                br_taken,
    input  logic [31:0]         ir,
    input  logic [31:0]         next_pc,
    output logic                c_fetch_stall,
    output logic [SEL_PC_W-1:0] c_pc_sel,
    output logic                c_br_taken,
    output logic [31:0]         c_next_pc,
    output logic                halted,
    output logic                err_timeout,
    output logic                err_misalign,
    output logic [CNT_W-1:0]    instret,
    output logic [1:0]          state
);

    seq_state_t          state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic [SEL_PC_W-1:0] sel_q, sel_d;
    logic                br_q, br_d;
    logic                halted_q, halted_d;
    logic                err_t_q, err_t_d;
    logic                err_m_q, err_m_d;
    logic [CNT_W-1:0]    instret_q, instret_d;
    logic                tmr_clear, tmr_en, tmr_expired;
    logic                unused_ir;

    assign unused_ir = ^ir[31:7];

    seq_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            sel_q     <= '0;
            br_q      <= 1'b0;
            halted_q  <= 1'b0;
            err_t_q   <= 1'b0;
            err_m_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sel_q     <= sel_d;
            br_q      <= br_d;
            halted_q  <= halted_d;
            err_t_q   <= err_t_d;
            err_m_q   <= err_m_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sel_d     = sel_q;
        br_d      = br_q;
        halted_d  = halted_q;
        err_t_d   = err_t_q;
        err_m_d   = err_m_q;
        instret_d = instret_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        c_next_pc = pc_q;
        case (state_q)
            S_FETCH: state_d = S_DE;
            S_DE: begin
                sel_d = pc_sel;
                br_d  = br_taken;
                if (HALT_ON_SYSTEM && is_system(ir[6:0])) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d   = S_MW;
                    tmr_clear = 1'b1;
                end
            end
            S_MW: begin
                // memory_done is checked first so it beats a same-cycle expiry.
                if (memory_done) begin
                    if (next_pc[1:0] != 2'b00) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        err_m_d  = 1'b1;
                    end else begin
                        state_d   = S_FETCH;
                        c_next_pc = next_pc;
                        pc_d      = next_pc;
                        instret_d = instret_q + CNT_W'(1);
                        sel_d     = '0;
                        br_d      = 1'b0;
                    end
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        err_t_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign c_fetch_stall = (state_q != S_FETCH);
    assign c_pc_sel      = sel_q;
    assign c_br_taken    = br_q;
    assign halted        = halted_q;
    assign err_timeout   = err_t_q;
    assign err_misalign  = err_m_q;
    assign instret       = instret_q;
    assign state         = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: per-instruction timeline model, directed and
// randomized instructions, timeout (two timeout settings), halts and reset.
module tb_core_sequencer;
    import core_sequencer_pkg::*;

    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          memory_done = 1'b0;
    logic [SW-1:0] pc_sel = '0;
    logic          br_taken = 1'b0;
    logic [31:0]   ir = 32'h0000_0013;
    logic [31:0]   next_pc = '0;

    logic          c_fetch_stall, c_br_taken, halted, err_timeout, err_misalign;
    logic [SW-1:0] c_pc_sel;
    logic [31:0]   c_next_pc, instret;
    logic [1:0]    state;

    logic          c_fetch_stall_4, c_br_taken_4, halted_4, err_timeout_4, err_misalign_4;
    logic [SW-1:0] c_pc_sel_4;
    logic [31:0]   c_next_pc_4, instret_4;
    logic [1:0]    state_4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instret;

    logic [1:0]    obs_state[$], obs4_state[$];
    logic [31:0]   obs_cnp[$];
    logic [SW-1:0] obs_sel[$];
    logic          obs_br[$], obs_stall[$];
    logic [1:0]    exp_state_q[$];
    logic [31:0]   exp_q[$];
    logic [SW-1:0] exp_sel_q[$];
    logic          exp_br_q[$], exp_stall_q[$];

    core_sequencer #(.SEL_PC_W(SW), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .memory_done(memory_done), .pc_sel(pc_sel),
        .br_taken(br_taken), .ir(ir), .next_pc(next_pc),
        .c_fetch_stall(c_fetch_stall), .c_pc_sel(c_pc_sel), .c_br_taken(c_br_taken),
        .c_next_pc(c_next_pc), .halted(halted), .err_timeout(err_timeout),
        .err_misalign(err_misalign), .instret(instret), .state(state)
    );

    core_sequencer #(.SEL_PC_W(SW), .MEM_TIMEOUT(4)) dut4 (
        .clk(clk), .rst(rst), .memory_done(memory_done), .pc_sel(pc_sel),
        .br_taken(br_taken), .ir(ir), .next_pc(next_pc),
        .c_fetch_stall(c_fetch_stall_4), .c_pc_sel(c_pc_sel_4), .c_br_taken(c_br_taken_4),
        .c_next_pc(c_next_pc_4), .halted(halted_4), .err_timeout(err_timeout_4),
        .err_misalign(err_misalign_4), .instret(instret_4), .state(state_4)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b0;
        memory_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m_pc = 32'h0;
        m_instret = 32'h0;
    endtask

    task automatic clear_obs();
        obs_state.delete(); obs4_state.delete(); obs_cnp.delete();
        obs_sel.delete(); obs_br.delete(); obs_stall.delete();
        exp_state_q.delete(); exp_q.delete(); exp_sel_q.delete();
        exp_br_q.delete(); exp_stall_q.delete();
    endtask

    // Driver: entered and left 1 time unit after a rising edge. memory_done
    // rises on the (waits+1)-th S_MW cycle, counted from the instruction start.
    task automatic exec_instr(input logic [31:0] ir_v, input logic [SW-1:0] sel,
                              input logic br, input logic [31:0] npc,
                              input int waits, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            ir = ir_v; pc_sel = sel; br_taken = br; next_pc = npc;
            memory_done = (k == 2 + waits);
            #1;
            obs_state.push_back(state);
            obs4_state.push_back(state_4);
            obs_cnp.push_back(c_next_pc);
            obs_sel.push_back(c_pc_sel);
            obs_br.push_back(c_br_taken);
            obs_stall.push_back(c_fetch_stall);
            @(posedge clk);
            #1;
        end
        memory_done = 1'b0;
    endtask

    // Reference: per-instruction timeline. kind 0 = commit, 1 = SYSTEM halt,
    // 2 = misaligned halt. Instructions always start from a clean S_FETCH.
    task automatic expect_instr(input logic [SW-1:0] sel, input logic br,
                                input logic [31:0] npc, input int waits, input int kind);
        exp_state_q.push_back(2'd0); exp_q.push_back(m_pc);
        exp_sel_q.push_back('0); exp_br_q.push_back(1'b0); exp_stall_q.push_back(1'b0);
        exp_state_q.push_back(2'd1); exp_q.push_back(m_pc);
        exp_sel_q.push_back('0); exp_br_q.push_back(1'b0); exp_stall_q.push_back(1'b1);
        if (kind != 1) begin
            for (int j = 0; j <= waits; j++) begin
                exp_state_q.push_back(2'd2);
                exp_q.push_back((j == waits && kind == 0) ? npc : m_pc);
                exp_sel_q.push_back(sel); exp_br_q.push_back(br); exp_stall_q.push_back(1'b1);
            end
        end
        if (kind == 0) begin
            m_pc = npc;
            m_instret = m_instret + 1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_tests++;
        if (c_next_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", c_next_pc); end
        n_tests++;
        if ({c_pc_sel, c_br_taken, c_fetch_stall} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got sel=%b br=%b stall=%b want 0", c_pc_sel, c_br_taken, c_fetch_stall);
        end
        n_tests++;
        if ({halted, err_timeout, err_misalign} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {halted, err_timeout, err_misalign});
        end
        n_tests++;
        if (instret !== 32'h0) begin n_fail++; $display("FAIL reset_instret: got %0d want 0", instret); end
    endtask

    task automatic test_sequential();
        logic [1:0] walk[4];
        walk = '{2'd0, 2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 3; i++) begin
            clear_obs();
            exec_instr(32'h0000_0013, '0, 1'b0, m_pc + 4, 0, 3);
            obs_state.push_back(state);
            expect_instr('0, 1'b0, m_pc + 4, 0, 0);
            if (i == 0) begin
                for (int k = 0; k < 4; k++) begin
                    n_tests++;
                    if (obs_state[k] !== walk[k]) begin
                        n_fail++; $display("FAIL seq_walk[%0d]: got %0d want %0d", k, obs_state[k], walk[k]);
                    end
                end
                for (int k = 0; k < 3; k++) begin
                    n_tests++;
                    if (obs_cnp[k] !== exp_q[k]) begin
                        n_fail++; $display("FAIL seq_cnp[%0d]: got %h want %h", k, obs_cnp[k], exp_q[k]);
                    end
                end
            end
            if (i == 0 || i == 2) begin
                n_tests++;
                if (instret !== m_instret) begin
                    n_fail++; $display("FAIL seq_instret[%0d]: got %0d want %0d", i, instret, m_instret);
                end
            end
        end
    endtask

    task automatic test_branch();
        clear_obs();
        expect_instr(2'b01, 1'b1, 32'h40, 2, 0);
        exec_instr(32'h0000_0063, 2'b01, 1'b1, 32'h40, 2, 5);
        for (int k = 2; k < 5; k++) begin
            n_tests++;
            if (obs_sel[k] !== 2'b01 || obs_br[k] !== 1'b1) begin
                n_fail++; $display("FAIL br_latched[%0d]: got sel=%b br=%b want 01/1", k, obs_sel[k], obs_br[k]);
            end
        end
        n_tests++;
        if (obs_cnp[4] !== 32'h40) begin n_fail++; $display("FAIL br_commit: got %h want 40", obs_cnp[4]); end
        n_tests++;
        if (state !== 2'b00 || c_next_pc !== 32'h40 || c_pc_sel !== 2'b00 || c_br_taken !== 1'b0) begin
            n_fail++; $display("FAIL br_after: got st=%0d pc=%h sel=%b br=%b want 0/40/00/0", state, c_next_pc, c_pc_sel, c_br_taken);
        end
    endtask

    task automatic test_wait();
        int mw;
        clear_obs();
        mw = 0;
        exec_instr(32'h0000_0013, '0, 1'b0, m_pc + 4, 5, 8);
        expect_instr('0, 1'b0, m_pc + 4, 5, 0);
        foreach (obs_state[k]) if (obs_state[k] == 2'd2) mw++;
        n_tests++;
        if (mw != 6) begin n_fail++; $display("FAIL wait_mw_cycles: got %0d want 6", mw); end
        n_tests++;
        if (state !== 2'b00 || err_timeout !== 1'b0 || halted !== 1'b0 || instret !== m_instret) begin
            n_fail++; $display("FAIL wait_commit: got st=%0d to=%b h=%b ir=%0d want 0/0/0/%0d", state, err_timeout, halted, instret, m_instret);
        end
    endtask

    task automatic test_random();
        logic [31:0] r_ir, npc;
        logic [SW-1:0] sel;
        logic br;
        int waits;
        for (int i = 0; i < 40; i++) begin
            clear_obs();
            r_ir = $urandom();
            if (r_ir[6:0] == OPC_SYSTEM) r_ir[6:0] = 7'h33;
            sel = SW'($urandom_range(0, 3));
            br = 1'($urandom_range(0, 1));
            npc = {$urandom(), 2'b00} >> 2 << 2;
            waits = $urandom_range(0, 6);
            exec_instr(r_ir, sel, br, npc, waits, 3 + waits);
            expect_instr(sel, br, npc, waits, 0);
            for (int k = 0; k < exp_state_q.size(); k++) begin
                n_tests++;
                if (obs_state[k] !== exp_state_q[k] || obs_cnp[k] !== exp_q[k] || obs_sel[k] !== exp_sel_q[k]
                    || obs_br[k] !== exp_br_q[k] || obs_stall[k] !== exp_stall_q[k]) begin
                    n_fail++;
                    $display("FAIL rand[%0d][%0d]: got st=%0d pc=%h sel=%b br=%b stall=%b want %0d/%h/%b/%b/%b",
                             i, k, obs_state[k], obs_cnp[k], obs_sel[k], obs_br[k], obs_stall[k],
                             exp_state_q[k], exp_q[k], exp_sel_q[k], exp_br_q[k], exp_stall_q[k]);
                end
            end
            n_tests++;
            if (state !== 2'b00 || instret !== m_instret || c_next_pc !== m_pc) begin
                n_fail++; $display("FAIL rand_end[%0d]: got st=%0d ir=%0d pc=%h want 0/%0d/%h", i, state, instret, c_next_pc, m_instret, m_pc);
            end
        end
    endtask

    task automatic test_system();
        clear_obs();
        exec_instr(32'h0000_0073, 2'b10, 1'b1, m_pc + 4, 0, 2);
        expect_instr(2'b10, 1'b1, m_pc + 4, 0, 1);
        n_tests++;
        if (obs_state[0] !== 2'd0 || obs_state[1] !== 2'd1) begin
            n_fail++; $display("FAIL sys_walk: got %0d,%0d want 0,1", obs_state[0], obs_state[1]);
        end
        for (int k = 0; k < 3; k++) begin
            memory_done = 1'b1;
            next_pc = 32'h0000_1000;
            #1;
            n_tests++;
            if (state !== 2'b11 || halted !== 1'b1 || c_fetch_stall !== 1'b1 || instret !== m_instret
                || c_next_pc !== m_pc || err_timeout !== 1'b0 || err_misalign !== 1'b0) begin
                n_fail++; $display("FAIL sys_halt[%0d]: got st=%0d h=%b stall=%b ir=%0d pc=%h want 3/1/1/%0d/%h",
                                   k, state, halted, c_fetch_stall, instret, c_next_pc, m_instret, m_pc);
            end
            @(posedge clk); #1;
        end
        memory_done = 1'b0;
        do_reset();
    endtask

    task automatic test_misalign();
        clear_obs();
        exec_instr(32'h0000_0013, '0, 1'b0, 32'h100, 0, 3);
        expect_instr('0, 1'b0, 32'h100, 0, 0);
        clear_obs();
        exec_instr(32'h0000_0013, '0, 1'b0, 32'h42, 1, 4);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (obs_cnp[k] !== 32'h100) begin
                n_fail++; $display("FAIL mis_cnp[%0d]: got %h want 100", k, obs_cnp[k]);
            end
        end
        n_tests++;
        if (state !== 2'b11 || err_misalign !== 1'b1 || halted !== 1'b1 || err_timeout !== 1'b0
            || instret !== m_instret || c_next_pc !== 32'h100) begin
            n_fail++; $display("FAIL mis_halt: got st=%0d em=%b h=%b to=%b ir=%0d pc=%h want 3/1/1/0/%0d/100",
                               state, err_misalign, halted, err_timeout, instret, c_next_pc, m_instret);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        clear_obs();
        exec_instr(32'h0000_0013, '0, 1'b0, 32'h4, 1000, 18);
        for (int k = 2; k < 6; k++) begin
            n_tests++;
            if (obs4_state[k] !== 2'd2) begin n_fail++; $display("FAIL to4_mw[%0d]: got %0d want 2", k, obs4_state[k]); end
        end
        n_tests++;
        if (obs4_state[6] !== 2'd3) begin n_fail++; $display("FAIL to4_halt_at: got %0d want 3", obs4_state[6]); end
        n_tests++;
        if (err_timeout_4 !== 1'b1 || halted_4 !== 1'b1 || c_fetch_stall_4 !== 1'b1 || err_misalign_4 !== 1'b0) begin
            n_fail++; $display("FAIL to4_flags: got to=%b h=%b stall=%b em=%b want 1/1/1/0", err_timeout_4, halted_4, c_fetch_stall_4, err_misalign_4);
        end
        n_tests++;
        if (obs_state[17] !== 2'd2) begin n_fail++; $display("FAIL to16_last_mw: got %0d want 2", obs_state[17]); end
        n_tests++;
        if (state !== 2'b11 || err_timeout !== 1'b1 || halted !== 1'b1 || err_misalign !== 1'b0 || instret !== 32'h0) begin
            n_fail++; $display("FAIL to16_flags: got st=%0d to=%b h=%b em=%b ir=%0d want 3/1/1/0/0", state, err_timeout, halted, err_misalign, instret);
        end
        do_reset();
    endtask

    task automatic test_timeout_boundary();
        clear_obs();
        exec_instr(32'h0000_0013, '0, 1'b0, 32'h8, 3, 6);
        n_tests++;
        if (state_4 !== 2'b00 || err_timeout_4 !== 1'b0 || halted_4 !== 1'b0 || instret_4 !== 32'h1 || c_next_pc_4 !== 32'h8) begin
            n_fail++; $display("FAIL to4_done_wins: got st=%0d to=%b h=%b ir=%0d pc=%h want 0/0/0/1/8",
                               state_4, err_timeout_4, halted_4, instret_4, c_next_pc_4);
        end
        do_reset();
    endtask

    task automatic test_reset_priority();
        clear_obs();
        exec_instr(32'h0000_0013, '0, 1'b0, 32'h80, 0, 3);
        exec_instr(32'h0000_0013, '0, 1'b0, 32'h20, 0, 2);
        n_tests++;
        if (state !== 2'b10) begin n_fail++; $display("FAIL rp_in_mw: got %0d want 2", state); end
        memory_done = 1'b1; next_pc = 32'h20; rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; memory_done = 1'b0;
        m_pc = 32'h0; m_instret = 32'h0;
        n_tests++;
        if (state !== 2'b00 || c_next_pc !== 32'h0 || instret !== 32'h0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL rp_mw: got st=%0d pc=%h ir=%0d h=%b want 0/0/0/0", state, c_next_pc, instret, halted);
        end
        clear_obs();
        exec_instr(32'h0010_0073, '0, 1'b0, 32'h4, 0, 2);
        n_tests++;
        if (state !== 2'b11 || halted !== 1'b1) begin n_fail++; $display("FAIL rp_halt_enter: got st=%0d h=%b want 3/1", state, halted); end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        n_tests++;
        if (state !== 2'b00 || halted !== 1'b0 || instret !== 32'h0 || c_next_pc !== 32'h0) begin
            n_fail++; $display("FAIL rp_halt: got st=%0d h=%b ir=%0d pc=%h want 0/0/0/0", state, halted, instret, c_next_pc);
        end
        clear_obs();
        exec_instr(32'h0000_0013, '0, 1'b0, 32'h4, 0, 3);
        n_tests++;
        if (instret !== 32'h1 || c_next_pc !== 32'h4) begin
            n_fail++; $display("FAIL rp_recover: got ir=%0d pc=%h want 1/4", instret, c_next_pc);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_wait();
        test_random();
        test_system();
        test_misalign();
        test_timeout();
        test_timeout_boundary();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
